// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// fetch_stage_if : IF-stage bus bundle (HDU controls, ID redirect, imem, IF/ID)
// Revision 1.0
// ============================================================================
interface fetch_stage_if #(
    parameter int CNT_W = 16
);
    logic              PCWrite;
    logic              IF_ID_Write;
    logic              branch_taken_ID;
    logic [31:0]       branch_target_ID;
    logic [31:0]       imem_rdata;
    logic [31:0]       imem_addr;
    logic [31:0]       IF_ID_PC;
    logic [31:0]       IF_ID_PC4;
    logic [31:0]       IF_ID_Instr;
    logic              IF_ID_Valid;
    logic              misalign_err;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    // Environment side: HDU, ID stage and instruction memory.
    modport master (
        output PCWrite, IF_ID_Write, branch_taken_ID, branch_target_ID, imem_rdata,
        input  imem_addr, IF_ID_PC, IF_ID_PC4, IF_ID_Instr, IF_ID_Valid,
               misalign_err, stall_cnt, flush_cnt
    );

    // Fetch stage side.
    modport slave (
        input  PCWrite, IF_ID_Write, branch_taken_ID, branch_target_ID, imem_rdata,
        output imem_addr, IF_ID_PC, IF_ID_PC4, IF_ID_Instr, IF_ID_Valid,
               misalign_err, stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage : RV32I IF stage - PC, IF/ID register, redirect, stall/flush counters
// Revision 1.0
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 16
) (
    input  wire logic     clk,
    input  wire logic     reset,
    fetch_stage_if.slave  bus
);

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q;
    logic [31:0]       pc_q;
    logic [31:0]       ifid_pc_q;
    logic [31:0]       ifid_instr_q;
    logic              ifid_valid_q;
    logic              misalign_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;

    logic [31:0]       pc_inc_d;
    logic [31:0]       redirect_pc_d;
    logic [CNT_W-1:0]  stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_d;

    assign pc_inc_d      = pc_q + 32'd4;
    // Low address bits are dropped so the PC always stays word aligned.
    assign redirect_pc_d = {bus.branch_target_ID[31:2], 2'b00};
    assign stall_cnt_d   = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
    assign flush_cnt_d   = (&flush_cnt_q) ? flush_cnt_q : flush_cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= 32'h0000_0000;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            case (state_q)
                BOOT: begin
                    pc_q         <= pc_inc_d;
                    ifid_pc_q    <= pc_q;
                    ifid_instr_q <= bus.imem_rdata;
                    ifid_valid_q <= 1'b1;
                    state_q      <= RUN;
                end
                RUN: begin
                    if (bus.branch_taken_ID) begin
                        // Taken branch wins over any HDU freeze and squashes the wrong-path fetch.
                        pc_q         <= redirect_pc_d;
                        ifid_pc_q    <= pc_q;
                        ifid_instr_q <= NOP_INSTR;
                        ifid_valid_q <= 1'b0;
                        flush_cnt_q  <= flush_cnt_d;
                        if (bus.branch_target_ID[1:0] != 2'b00) begin
                            misalign_q <= 1'b1;
                        end
                    end else begin
                        if (bus.PCWrite) begin
                            pc_q <= pc_inc_d;
                        end else begin
                            stall_cnt_q <= stall_cnt_d;
                        end
                        if (bus.IF_ID_Write) begin
                            ifid_pc_q    <= pc_q;
                            ifid_instr_q <= bus.imem_rdata;
                            ifid_valid_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    assign bus.imem_addr    = pc_q;
    assign bus.IF_ID_PC     = ifid_pc_q;
    assign bus.IF_ID_PC4    = ifid_pc_q + 32'd4;
    assign bus.IF_ID_Instr  = ifid_instr_q;
    assign bus.IF_ID_Valid  = ifid_valid_q;
    assign bus.misalign_err = misalign_q;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.flush_cnt    = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// tb_fetch_stage : two fetch_stage instances (RESET_PC=0x100/CNT_W=4 and
// RESET_PC=0xFFFF_FFF8/CNT_W=16) driven in lockstep against a behavioural model
// Revision 1.0
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] C_NOP     = 32'h0000_0013;
    localparam logic [31:0] C_RPC_A   = 32'h0000_0100;
    localparam logic [31:0] C_RPC_B   = 32'hFFFF_FFF8;
    localparam int          C_CW_A    = 4;
    localparam int          C_CW_B    = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ifpc;
        logic [31:0] ifinstr;
        logic        valid;
        logic        err;
        logic        booted;
        logic [31:0] sc;
        logic [31:0] fc;
    } model_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcw, ifw, bt;
    logic [31:0] tgt;
    int          checks   = 0;
    int          failures = 0;
    model_t      mA, mB;

    fetch_stage_if #(.CNT_W(C_CW_A)) ifA ();
    fetch_stage_if #(.CNT_W(C_CW_B)) ifB ();

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return 32'h0000_00A0 + a;
    endfunction

    assign ifA.PCWrite          = pcw;
    assign ifA.IF_ID_Write      = ifw;
    assign ifA.branch_taken_ID  = bt;
    assign ifA.branch_target_ID = tgt;
    assign ifA.imem_rdata       = imem_word(ifA.imem_addr);
    assign ifB.PCWrite          = pcw;
    assign ifB.IF_ID_Write      = ifw;
    assign ifB.branch_taken_ID  = bt;
    assign ifB.branch_target_ID = tgt;
    assign ifB.imem_rdata       = imem_word(ifB.imem_addr);

    fetch_stage #(.RESET_PC(C_RPC_A), .NOP_INSTR(C_NOP), .CNT_W(C_CW_A)) u_dut_a (
        .clk   (clk),
        .reset (rst),
        .bus   (ifA.slave)
    );

    fetch_stage #(.RESET_PC(C_RPC_B), .NOP_INSTR(C_NOP), .CNT_W(C_CW_B)) u_dut_b (
        .clk   (clk),
        .reset (rst),
        .bus   (ifB.slave)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: one architectural step of the fetch stage from its rules.
    function automatic model_t step(input model_t m, input logic [31:0] rpc, input int cw,
                                    input logic r, input logic p, input logic w,
                                    input logic b, input logic [31:0] t);
        model_t      n   = m;
        logic [31:0] mx  = (32'd1 << cw) - 32'd1;
        if (r) begin
            n = '0;
            n.pc      = rpc;
            n.ifinstr = C_NOP;
        end else if (!m.booted) begin
            n.ifpc = m.pc; n.ifinstr = imem_word(m.pc); n.valid = 1'b1;
            n.pc = m.pc + 32'd4; n.booted = 1'b1;
        end else if (b) begin
            n.ifpc = m.pc; n.ifinstr = C_NOP; n.valid = 1'b0;
            n.pc = t & 32'hFFFF_FFFC;
            n.fc = (m.fc == mx) ? m.fc : m.fc + 32'd1;
            if (t % 4 != 0) n.err = 1'b1;
        end else begin
            if (w) begin
                n.ifpc = m.pc; n.ifinstr = imem_word(m.pc); n.valid = 1'b1;
            end
            if (p) n.pc = m.pc + 32'd4;
            else   n.sc = (m.sc == mx) ? m.sc : m.sc + 32'd1;
        end
        return n;
    endfunction

    task automatic cmp_model(input string p, input model_t m,
                             input logic [31:0] addr, input logic [31:0] ipc,
                             input logic [31:0] ipc4, input logic [31:0] instr,
                             input logic valid, input logic err,
                             input logic [31:0] sc, input logic [31:0] fc);
        chk_eq({p, "_imem_addr"}, addr, m.pc);
        chk_eq({p, "_IF_ID_PC"}, ipc, m.ifpc);
        chk_eq({p, "_IF_ID_PC4"}, ipc4, m.ifpc + 32'd4);
        chk_eq({p, "_IF_ID_Instr"}, instr, m.ifinstr);
        chk_eq({p, "_IF_ID_Valid"}, 32'(valid), 32'(m.valid));
        chk_eq({p, "_misalign_err"}, 32'(err), 32'(m.err));
        chk_eq({p, "_stall_cnt"}, sc, m.sc);
        chk_eq({p, "_flush_cnt"}, fc, m.fc);
    endtask

    task automatic cycle(input logic r, input logic p, input logic w,
                         input logic b, input logic [31:0] t);
        model_t nA, nB;
        rst = r; pcw = p; ifw = w; bt = b; tgt = t;
        nA = step(mA, C_RPC_A, C_CW_A, r, p, w, b, t);
        nB = step(mB, C_RPC_B, C_CW_B, r, p, w, b, t);
        @(posedge clk);
        #1;
        mA = nA;
        mB = nB;
        cmp_model("A", mA, ifA.imem_addr, ifA.IF_ID_PC, ifA.IF_ID_PC4, ifA.IF_ID_Instr,
                  ifA.IF_ID_Valid, ifA.misalign_err, 32'(ifA.stall_cnt), 32'(ifA.flush_cnt));
        cmp_model("B", mB, ifB.imem_addr, ifB.IF_ID_PC, ifB.IF_ID_PC4, ifB.IF_ID_Instr,
                  ifB.IF_ID_Valid, ifB.misalign_err, 32'(ifB.stall_cnt), 32'(ifB.flush_cnt));
    endtask

    task automatic chk_reset_values();
        chk_eq("rst_A_addr", ifA.imem_addr, C_RPC_A);
        chk_eq("rst_B_addr", ifB.imem_addr, C_RPC_B);
        chk_eq("rst_A_ifpc", ifA.IF_ID_PC, 32'h0);
        chk_eq("rst_A_instr", ifA.IF_ID_Instr, C_NOP);
        chk_eq("rst_A_valid", 32'(ifA.IF_ID_Valid), 32'h0);
        chk_eq("rst_A_err", 32'(ifA.misalign_err), 32'h0);
        chk_eq("rst_A_cnts", {16'(ifA.stall_cnt), 16'(ifA.flush_cnt)}, 32'h0);
        chk_eq("rst_B_cnts", {ifB.stall_cnt, ifB.flush_cnt}, 32'h0);
    endtask

    initial begin
        int unsigned k;
        logic        rp, rw, rb, rr;
        mA = '0;
        mB = '0;
        rst = 1'b1; pcw = 1'b0; ifw = 1'b0; bt = 1'b0; tgt = 32'h0;

        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_reset_values();

        // Boot cycle, then one free-running cycle.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk_eq("boot_A_ifpc", ifA.IF_ID_PC, 32'h100);
        chk_eq("boot_A_valid", 32'(ifA.IF_ID_Valid), 32'h1);
        chk_eq("boot_B_addr", ifB.imem_addr, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk_eq("run_A_ifpc", ifA.IF_ID_PC, 32'h104);
        chk_eq("run_A_addr", ifA.imem_addr, 32'h108);
        chk_eq("wrap_B_addr", ifB.imem_addr, 32'h0);
        chk_eq("wrap_B_ifpc", ifB.IF_ID_PC, 32'hFFFF_FFFC);

        // Load-use freeze for two cycles, then release.
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_eq("lu_A_addr", ifA.imem_addr, 32'h108);
        chk_eq("lu_A_ifpc", ifA.IF_ID_PC, 32'h104);
        chk_eq("lu_A_stall", 32'(ifA.stall_cnt), 32'h2);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk_eq("lu_A_release_ifpc", ifA.IF_ID_PC, 32'h108);
        chk_eq("lu_A_release_instr", ifA.IF_ID_Instr, 32'h1A8);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk_eq("pre_br_A_addr", ifA.imem_addr, 32'h110);

        // Taken branch while the HDU freezes both registers.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
        chk_eq("br_A_instr", ifA.IF_ID_Instr, C_NOP);
        chk_eq("br_A_valid", 32'(ifA.IF_ID_Valid), 32'h0);
        chk_eq("br_A_addr", ifA.imem_addr, 32'h200);
        chk_eq("br_A_flush", 32'(ifA.flush_cnt), 32'h1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk_eq("br_A_tgt_ifpc", ifA.IF_ID_PC, 32'h200);
        chk_eq("br_A_tgt_valid", 32'(ifA.IF_ID_Valid), 32'h1);

        // Misaligned redirect sets the sticky flag; an aligned one leaves it set.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h203);
        chk_eq("mis_A_addr", ifA.imem_addr, 32'h200);
        chk_eq("mis_A_err", 32'(ifA.misalign_err), 32'h1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h300);
        chk_eq("mis_A_sticky", 32'(ifA.misalign_err), 32'h1);

        // Long freeze saturates the 4-bit counter of instance A.
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_eq("sat_A_stall", 32'(ifA.stall_cnt), 32'hF);
        chk_eq("sat_B_stall", 32'(ifB.stall_cnt), 32'd22);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_eq("sat_A_hold", 32'(ifA.stall_cnt), 32'hF);

        // Randomized traffic, every cycle checked against the model.
        for (int i = 0; i < 800; i++) begin
            k = $urandom_range(0, 99);
            if (k < 55)      begin rp = 1'b1; rw = 1'b1; end
            else if (k < 85) begin rp = 1'b0; rw = 1'b0; end
            else if (k < 93) begin rp = 1'b1; rw = 1'b0; end
            else             begin rp = 1'b0; rw = 1'b1; end
            rb = ($urandom_range(0, 5) == 0);
            rr = ($urandom_range(0, 299) == 0);
            cycle(rr, rp, rw, rb, $urandom);
        end

        // Reset asserted on a branch-taken, stalled cycle.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0401);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0400);
        chk_reset_values();
        chk_eq("rst_br_A_pc4", ifA.IF_ID_PC4, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
